// File: rtl/fp_mul_pkg.sv
// Shared types, flag-vector layout and constant helpers for the pipelined FP multiplier.
package fp_mul_pkg;

    typedef struct packed {
        logic sign;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } fp_class_t;

    localparam int FLAG_W         = 4;
    localparam int FLAG_UNDERFLOW = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_EXCEPTION = 2;
    localparam int FLAG_INVALID   = 3;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits: {0, all-ones, 1, 0...}.
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational classify and hidden-bit insertion for one {sign,exp,man} operand.
module fp_unpack
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op_i,
    output fp_class_t            cls_o,
    output logic [EXP_W-1:0]     exp_o,
    output logic [MAN_W:0]       sig_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_ones;

    assign exp_f    = op_i[MAN_W +: EXP_W];
    assign man_f    = op_i[MAN_W-1:0];
    assign exp_ones = &exp_f;

    // Subnormals collapse to zero, so the mantissa is ignored when exp is 0.
    assign cls_o.sign = op_i[EXP_W+MAN_W];
    assign cls_o.zero = (exp_f == '0);
    assign cls_o.inf  = exp_ones & (man_f == '0);
    assign cls_o.nan  = exp_ones & (|man_f);
    assign cls_o.snan = exp_ones & (|man_f) & ~man_f[MAN_W-1];

    assign exp_o = exp_f;
    assign sig_o = {1'b1, man_f};

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / multiply / normalise-round-pack), RNE, FTZ,
// with a single global stall driven by the output handshake.
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FTZ   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a_operand,
    input  logic [EXP_W+MAN_W:0]   b_operand,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   exception,
    output logic                   invalid,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_X   = XW'(bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [63:0]          QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];

    generate
        if (FTZ != 1) begin : g_bad_ftz
            $error("fp_mul_pipe: only FTZ=1 is supported");
        end
        if (EXP_W < 4 || MAN_W < 3) begin : g_bad_width
            $error("fp_mul_pipe: EXP_W must be >= 4 and MAN_W >= 3");
        end
    endgenerate

    typedef struct packed {
        logic                   sign;
        logic                   nan_res;
        logic                   inf_res;
        logic                   zero_res;
        logic                   invalid;
        logic                   exception;
        logic signed [XW-1:0]   exp;
    } ctl_t;

    logic advance;

    // Stage 1: unpack both operands.
    logic [W-1:0]     ops  [2];
    fp_class_t        cls  [2];
    logic [EXP_W-1:0] exps [2];
    logic [MAN_W:0]   sigs [2];

    assign ops[0] = a_operand;
    assign ops[1] = b_operand;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack (
                .op_i  (ops[gi]),
                .cls_o (cls[gi]),
                .exp_o (exps[gi]),
                .sig_o (sigs[gi])
            );
        end
    endgenerate

    ctl_t           c1_d, c1_q, c2_q;
    logic [MAN_W:0] sa_q, sb_q;
    logic [PW-1:0]  prod_q;
    logic           v1_q, v2_q, v3_q;
    logic           zero_x_inf;

    assign zero_x_inf = (cls[0].zero & cls[1].inf) | (cls[0].inf & cls[1].zero);

    always_comb begin
        c1_d           = '0;
        c1_d.sign      = cls[0].sign ^ cls[1].sign;
        c1_d.nan_res   = cls[0].nan | cls[1].nan | zero_x_inf;
        c1_d.inf_res   = cls[0].inf | cls[1].inf;
        c1_d.zero_res  = cls[0].zero | cls[1].zero;
        c1_d.invalid   = cls[0].snan | cls[1].snan | zero_x_inf;
        c1_d.exception = (&exps[0]) | (&exps[1]);
        c1_d.exp       = $signed({2'b00, exps[0]}) + $signed({2'b00, exps[1]}) - BIAS_X;
    end

    // Stage 3: normalise, round to nearest even, then resolve specials by priority.
    logic [PW-2:0]          norm;
    logic [MAN_W-1:0]       mant;
    logic                   guard, sticky, rnd;
    logic [MAN_W:0]         mant_r;
    logic signed [XW-1:0]   exp_f;
    logic [W-1:0]           res_d, res_q;
    logic [FLAG_W-1:0]      flags_d, flags_q;

    always_comb begin
        norm    = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
        mant    = norm[PW-2 -: MAN_W];
        guard   = norm[MAN_W];
        sticky  = |norm[MAN_W-1:0];
        rnd     = guard & (sticky | mant[0]);
        mant_r  = {1'b0, mant} + (MAN_W+1)'(rnd);
        exp_f   = c2_q.exp + $signed(XW'(prod_q[PW-1])) + $signed(XW'(mant_r[MAN_W]));

        res_d                   = '0;
        flags_d                 = '0;
        flags_d[FLAG_INVALID]   = c2_q.invalid;
        flags_d[FLAG_EXCEPTION] = c2_q.exception;
        if (c2_q.nan_res) begin
            res_d = QNAN;
        end else if (c2_q.inf_res) begin
            res_d = {c2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (c2_q.zero_res) begin
            res_d = {c2_q.sign, {(W-1){1'b0}}};
        end else if (exp_f >= EXP_MAX) begin
            res_d                   = {c2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d[FLAG_OVERFLOW]  = 1'b1;
        end else if (exp_f <= EXP_ZERO) begin
            res_d                   = {c2_q.sign, {(W-1){1'b0}}};
            flags_d[FLAG_UNDERFLOW] = 1'b1;
        end else begin
            res_d = {c2_q.sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
        end
    end

    // One stall for the whole pipe: every stage holds while the output is blocked.
    assign in_ready = ~(v3_q & ~out_ready);
    assign advance  = in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            c1_q    <= '0;
            c2_q    <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            prod_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (advance) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                c1_q <= c1_d;
                sa_q <= sigs[0];
                sb_q <= sigs[1];
            end
            if (v1_q) begin
                c2_q   <= c1_q;
                prod_q <= PW'(sa_q) * PW'(sb_q);
            end
            if (v2_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = v3_q;
    assign result    = res_q;
    assign exception = flags_q[FLAG_EXCEPTION];
    assign invalid   = flags_q[FLAG_INVALID];
    assign overflow  = flags_q[FLAG_OVERFLOW];
    assign underflow = flags_q[FLAG_UNDERFLOW];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe: single precision table, backpressure, async reset,
// and a half-precision instance.
module tb_fp_mul_pipe;
    import fp_mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, exception, invalid, overflow, underflow;
    logic [31:0] a_op = '0, b_op = '0, result;
    logic [3:0]  sp_flags;

    logic        h_in_valid = 1'b0, h_out_ready = 1'b1;
    logic        h_in_ready, h_out_valid, h_exc, h_inv, h_ovf, h_unf;
    logic [15:0] h_a = '0, h_b = '0, h_result;
    logic [3:0]  hp_flags;

    int checks = 0;
    int passes = 0;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .FTZ(1)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_operand(a_op), .b_operand(b_op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .exception(exception), .invalid(invalid),
        .overflow(overflow), .underflow(underflow)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .FTZ(1)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a_operand(h_a), .b_operand(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .exception(h_exc), .invalid(h_inv),
        .overflow(h_ovf), .underflow(h_unf)
    );

    always #5 clk = ~clk;

    always_comb begin
        sp_flags                 = '0;
        sp_flags[FLAG_INVALID]   = invalid;
        sp_flags[FLAG_EXCEPTION] = exception;
        sp_flags[FLAG_OVERFLOW]  = overflow;
        sp_flags[FLAG_UNDERFLOW] = underflow;
        hp_flags                 = '0;
        hp_flags[FLAG_INVALID]   = h_inv;
        hp_flags[FLAG_EXCEPTION] = h_exc;
        hp_flags[FLAG_OVERFLOW]  = h_ovf;
        hp_flags[FLAG_UNDERFLOW] = h_unf;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("check %-28s got %h ok", name, act);
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // flg is {invalid, exception, overflow, underflow}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
        string       name;
    } vec_t;

    vec_t vecs[15];

    task automatic sp_op(input vec_t v);
        int lat;
        @(negedge clk);
        a_op = v.a; b_op = v.b; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
        end while (!out_valid && lat < 8);
        check({v.name, " latency"}, 32'(lat), 32'd3);
        check({v.name, " result"}, result, v.res);
        check({v.name, " flags"}, 32'(sp_flags), 32'(v.flg));
    endtask

    task automatic hp_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] flg, input string name);
        int lat;
        @(negedge clk);
        h_a = a; h_b = b; h_in_valid = 1'b1; h_out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            h_in_valid = 1'b0;
        end while (!h_out_valid && lat < 8);
        check({name, " latency"}, 32'(lat), 32'd3);
        check({name, " result"}, 32'(h_result), 32'(res));
        check({name, " flags"}, 32'(hp_flags), 32'(flg));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_b [5];
        int          sent, got, extra, stale;
        bit          seen, acc;

        vecs[0]  = '{32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000, "mul_3x2"};
        vecs[1]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000, "rne_round"};
        vecs[2]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0000, "near_four"};
        vecs[3]  = '{32'h3F918E00, 32'h3FE12000, 32'h40000000, 4'b0000, "round_carry_out"};
        vecs[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0010, "overflow"};
        vecs[5]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0001, "underflow_pos"};
        vecs[6]  = '{32'h80800000, 32'h00800000, 32'h80000000, 4'b0001, "underflow_neg"};
        vecs[7]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1100, "zero_x_inf"};
        vecs[8]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0100, "ninf_x_two"};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1100, "snan_in"};
        vecs[10] = '{32'h7FC00000, 32'h40000000, 32'h7FC00000, 4'b0100, "qnan_in"};
        vecs[11] = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000, "negzero_x_fin"};
        vecs[12] = '{32'h00400000, 32'h40000000, 32'h00000000, 4'b0000, "subnormal_ftz"};
        vecs[13] = '{32'hC0400000, 32'h40000000, 32'hC0C00000, 4'b0000, "neg_3x2"};
        vecs[14] = '{32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0100, "inf_x_ninf"};

        // Reset state
        @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset result", result, 32'd0);
        check("reset flags", 32'(sp_flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) sp_op(vecs[i]);

        // Backpressure: five ops against a blocked consumer, then drain.
        bp_b[0] = 32'h40000000; bp_b[1] = 32'h40400000; bp_b[2] = 32'h40800000;
        bp_b[3] = 32'h40A00000; bp_b[4] = 32'h40C00000;
        sent = 0; got = 0; seen = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            if (cyc > 0) @(negedge clk);
            out_ready = (cyc >= 8);
            #1;
            if (out_valid && !seen) begin
                seen = 1;
                check("bp in_ready drop", 32'(in_ready), 32'd0);
                check("bp accepted before stall", 32'(sent), 32'd3);
            end
            if (out_valid && !out_ready) check("bp hold result", result, bp_b[0]);
            if (out_valid && out_ready) begin
                check($sformatf("bp out%0d", got), result, bp_b[got]);
                got++;
            end
            acc = 0;
            if (sent < 5) begin
                in_valid = 1'b1; a_op = 32'h3F800000; b_op = bp_b[sent];
                acc = in_ready;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp results drained", 32'(got), 32'd5);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        check("bp no duplicates", 32'(extra), 32'd0);

        // Asynchronous reset with two ops in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a_op = 32'h3F800000; b_op = 32'h40000000;
        @(negedge clk);
        b_op = 32'h40400000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst pre out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst async out_valid", 32'(out_valid), 32'd0);
        check("rst async in_ready", 32'(in_ready), 32'd1);
        check("rst async result", result, 32'd0);
        check("rst async flags", 32'(sp_flags), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst no stale output", 32'(stale), 32'd0);
        sp_op(vecs[0]);

        // Half precision instance.
        hp_op(16'h4200, 16'h4000, 16'h4600, 4'b0000, "hp_3x2");
        hp_op(16'h7BFF, 16'h4000, 16'h7C00, 4'b0010, "hp_overflow");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
